// File: rtl/output_mem_pkg.sv
// Shared sizes, FSM state type and address helper for the output collection memory.
package output_mem_pkg;

    localparam int ROW_W         = 2048;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_ROW = 64;
    localparam int ROWS          = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // 64*row + word, which is simply the two fields concatenated.
    function automatic logic [11:0] word_addr(input logic [5:0] row, input logic [5:0] word);
        return {row, word};
    endfunction

endpackage

// File: rtl/output_mem_32b_2048b.sv
// 4096 x 32 block RAM with a full-row (64-word) write port and a registered 32-bit read port.
module output_mem_32b_2048b #(
    parameter int WORDS_PER_ROW = 64,
    parameter int WORD_W        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [5:0]    wrow,
    input  logic [2047:0] wdata,
    input  logic          re,
    input  logic [11:0]   raddr,
    output logic [31:0]   rdata
);
    import output_mem_pkg::*;

    (* ram_style = "block" *) logic [WORD_W-1:0] mem [4096];

    // Word 0 of a row sits in the most significant 32 bits of the beat.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORDS_PER_ROW; i++) begin
                mem[word_addr(wrow, 6'(i))] <= wdata[ROW_W-1-WORD_W*i -: WORD_W];
            end
        end
    end

    // Read-first: a same-edge write is not visible until the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/output_collect_mem_2048b_32b.sv
// Collects 2048-bit result rows from the compute array into BRAM for PS readback.
//
// state   | meaning
// IDLE    | after reset, stream back-pressured, waiting for start
// COLLECT | window open, one row accepted per valid beat
// DONE    | all rows captured, done held until next start
module output_collect_mem_2048b_32b #(
    parameter int ROWS          = 64,
    parameter int WORDS_PER_ROW = 64,
    parameter int WORD_W        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [2047:0] s_data,
    input  logic          en_a,
    input  logic [3:0]    we_a,
    input  logic [11:0]   addr_a,
    input  logic [31:0]   din_a,
    output logic [31:0]   dout_a,
    output logic          busy,
    output logic          done,
    output logic          done_pulse,
    output logic [5:0]    row_cnt
);
    import output_mem_pkg::*;

    state_t     state_q, state_d;
    logic [5:0] row_q, row_d;
    logic       pulse_d;
    logic       accept;
    logic       last_row;
    logic       unused_axi_wr;

    // The AXI side is read-only; write enables and write data are dropped.
    assign unused_axi_wr = ^{we_a, din_a};

    assign accept   = s_valid && s_ready;
    assign last_row = (row_q == 6'(ROWS - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pulse_d = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    row_d   = '0;
                end
            end
            COLLECT: begin
                s_ready = !start;
                if (start) begin
                    row_d = '0;
                end else if (s_valid) begin
                    if (last_row) begin
                        state_d = DONE;
                        pulse_d = 1'b1;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 6'd1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = COLLECT;
                    row_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            done_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            done_pulse <= pulse_d;
        end
    end

    assign busy    = (state_q == COLLECT);
    assign done    = (state_q == DONE);
    assign row_cnt = row_q;

    output_mem_32b_2048b #(
        .WORDS_PER_ROW (WORDS_PER_ROW),
        .WORD_W        (WORD_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .wrow  (row_q),
        .wdata (s_data),
        .re    (en_a),
        .raddr (addr_a),
        .rdata (dout_a)
    );

endmodule

// File: tb/tb_output_collect_mem_2048b_32b.sv
// Randomized bench for output_collect_mem_2048b_32b against a word-array reference model.
module tb_output_collect_mem_2048b_32b;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [2047:0] s_data = '0;
    logic          en_a = 1'b0;
    logic [3:0]    we_a = 4'h0;
    logic [11:0]   addr_a = '0;
    logic [31:0]   din_a = '0;
    logic [31:0]   dout_a;
    logic          busy, done, done_pulse;
    logic [5:0]    row_cnt;

    output_collect_mem_2048b_32b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .en_a       (en_a),
        .we_a       (we_a),
        .addr_a     (addr_a),
        .din_a      (din_a),
        .dout_a     (dout_a),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse),
        .row_cnt    (row_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: matrix window flags, row index, and a flat word image.
    logic [31:0] ref_mem [4096];
    bit          ref_known [4096];
    bit          ref_collect = 0;
    bit          ref_done    = 0;
    bit          ref_pulse   = 0;
    int          ref_row     = 0;
    logic [31:0] ref_dout    = '0;
    bit          ref_dout_ok = 1;
    int          accepted    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2047:0] rand_row();
        logic [2047:0] r;
        for (int i = 0; i < 64; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [2047:0] pat_row(input int r);
        logic [2047:0] d;
        for (int i = 0; i < 64; i++) d[2047-32*i -: 32] = {8'(r), 8'(i), 16'hA5A5};
        return d;
    endfunction

    task automatic check_status();
        check("busy", 32'(busy), 32'(ref_collect));
        check("done", 32'(done), 32'(ref_done));
        check("done_pulse", 32'(done_pulse), 32'(ref_pulse));
        check("row_cnt", 32'(row_cnt), 32'(ref_row));
    endtask

    // One clock: drive inputs, check s_ready before the edge, then status and read data after it.
    task automatic tick(input bit st, input bit v, input logic [2047:0] d,
                        input bit en, input logic [11:0] addr);
        bit exp_ready, acc;
        start = st; s_valid = v; s_data = d; en_a = en; addr_a = addr;
        #1;
        exp_ready = ref_collect && !st;
        check("s_ready", 32'(s_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        if (en) begin
            ref_dout    = ref_mem[addr];
            ref_dout_ok = ref_known[addr];
        end
        acc = v && exp_ready;
        ref_pulse = 0;
        if (acc) begin
            accepted++;
            for (int i = 0; i < 64; i++) begin
                ref_mem[ref_row*64 + i]   = d[2047-32*i -: 32];
                ref_known[ref_row*64 + i] = 1;
            end
            if (ref_row == 63) begin
                ref_collect = 0; ref_done = 1; ref_pulse = 1; ref_row = 0;
            end else begin
                ref_row++;
            end
        end
        if (st) begin
            ref_collect = 1; ref_done = 0; ref_row = 0;
        end
        check_status();
        if (ref_dout_ok) check("dout_a", dout_a, ref_dout);
    endtask

    task automatic idle_read(input logic [11:0] addr);
        tick(0, 0, '0, 1, addr);
    endtask

    initial begin
        logic [2047:0] d3;
        logic [31:0]   old_w;
        int            budget;

        for (int i = 0; i < 4096; i++) begin ref_mem[i] = '0; ref_known[i] = 0; end

        // Reset values
        s_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_dout", dout_a, 32'd0);
        check_status();
        rst_n = 1'b1;

        // Idle: valid without start is never accepted
        for (int c = 0; c < 10; c++) tick(0, 1, rand_row(), 0, '0);

        // Full matrix of patterned rows
        tick(1, 0, '0, 0, '0);
        for (int r = 0; r < 64; r++) tick(0, 1, pat_row(r), 0, '0);
        check("done_after_63", 32'(done_pulse), 32'd1);
        tick(0, 0, '0, 1, 12'(64*5 + 7));
        check("pulse_one_cycle", 32'(done_pulse), 32'd0);
        check("rd_5_7", dout_a, 32'h0507A5A5);
        for (int c = 0; c < 8; c++) idle_read(12'($urandom_range(0, 4095)));

        // Back-pressure with random valid, random data and random concurrent reads
        tick(1, 0, '0, 0, '0);
        accepted = 0;
        budget   = 0;
        while (accepted < 64 && budget < 1000) begin
            tick(0, 1'($urandom), rand_row(), 1'($urandom), 12'($urandom_range(0, 4095)));
            budget++;
        end
        check("bp_rows_accepted", 32'(accepted), 32'd64);
        for (int a = 0; a < 4096; a++) idle_read(12'(a));

        // Restart mid-stream after row 20
        tick(1, 0, '0, 0, '0);
        for (int r = 0; r < 21; r++) tick(0, 1, rand_row(), 0, '0);
        check("pre_restart_cnt", 32'(row_cnt), 32'd21);
        tick(1, 1, rand_row(), 0, '0);
        check("restart_cnt", 32'(row_cnt), 32'd0);
        tick(0, 1, rand_row(), 0, '0);
        for (int a = 0; a < 64; a++) idle_read(12'(a));

        // Same-cycle read of a word while its row is written, then read again
        tick(0, 1, rand_row(), 0, '0);
        tick(0, 1, rand_row(), 0, '0);
        old_w = ref_mem[64*3];
        d3 = rand_row();
        tick(0, 1, d3, 1, 12'(64*3));
        check("rd_old", dout_a, old_w);
        idle_read(12'(64*3));
        check("rd_new", dout_a, d3[2047:2016]);

        // AXI writes are ignored
        old_w = ref_mem[0];
        we_a = 4'hF; din_a = 32'hDEADBEEF;
        tick(0, 0, '0, 1, '0);
        we_a = 4'h0; din_a = '0;
        idle_read('0);
        check("axi_wr_ignored", dout_a, old_w);

        // Reset in the middle of a collection window
        tick(0, 1, rand_row(), 0, '0);
        tick(0, 1, rand_row(), 0, '0);
        rst_n = 1'b0;
        #1;
        ref_collect = 0; ref_done = 0; ref_pulse = 0; ref_row = 0;
        ref_dout = '0; ref_dout_ok = 1;
        check_status();
        check("rst_mid_dout", dout_a, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 1, rand_row(), 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
